// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the hazard/pipeline-control unit
//   div_state_t : divider FSM states
//   FWD_*       : execute-stage forward-select encodings
package hazard_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/hazard_div_fsm.sv
// rtl/hazard_div_fsm.sv - multi-cycle divider occupancy FSM
//   clk, resetn       : clock, async active-low reset
//   div_req, exc      : divide in E, exception taken in M
//   div_busy          : FSM in RUN
//   div_done          : divide result valid in E this cycle
//   div_stall         : divider requires the pipeline to hold this cycle
module hazard_div_fsm #(
    parameter int DIV_CYCLES = 34
) (
    input  logic clk,
    input  logic resetn,
    input  logic div_req,
    input  logic exc,
    output logic div_busy,
    output logic div_done,
    output logic div_stall
);
    import hazard_pkg::*;

    localparam int CW = $clog2(DIV_CYCLES);
    // The counter holds the number of RUN cycles still to spend, so the
    // divide occupies E for 1 (IDLE) + DIV_CYCLES-2 (RUN) + 1 (DONE) cycles.
    localparam logic [CW-1:0] CNT_LOAD = CW'(DIV_CYCLES - 2);

    div_state_t    state, state_next;
    logic [CW-1:0] cnt, cnt_next;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (exc) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (div_req) begin
                        cnt_next   = CNT_LOAD;
                        // A two-cycle divide has no RUN phase at all.
                        state_next = (CNT_LOAD == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    cnt_next = cnt - CW'(1);
                    // Leave on the cycle the counter decrements to zero.
                    if (cnt <= CW'(1)) begin
                        state_next = DONE;
                    end
                end
                // divE is still the same instruction here, so it is ignored.
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    assign div_busy  = (state == RUN);
    assign div_done  = (state == DONE);
    assign div_stall = (state == RUN) || ((state == IDLE) && div_req);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - 5-stage MIPS hazard, forwarding and pipeline-control unit
//   clk, resetn                 : clock, async active-low reset
//   rsD/rtD/branchD             : decode sources and branch flag
//   rsE/rtE/writeregE/...       : execute sources, destination, write/load/divide flags
//   writeregM/regwriteM/...     : memory-stage destination, flags and exception
//   writeregW/regwriteW         : writeback destination and write-enable
//   forwarda/bD, forwarda/bE    : forwarding selects
//   stallF..M, flushD..W        : per-stage hold and bubble controls
//   div_busy/div_done           : divider status
//   stall_cnt                   : saturating count of cycles with stallF=1
module hazard_ctrl #(
    parameter int REG_AW       = 5,
    parameter int DIV_CYCLES   = 34,
    parameter int BRANCH_STALL = 1,
    parameter int CNT_W        = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [REG_AW-1:0] rsD,
    input  logic [REG_AW-1:0] rtD,
    input  logic              branchD,
    input  logic [REG_AW-1:0] rsE,
    input  logic [REG_AW-1:0] rtE,
    input  logic [REG_AW-1:0] writeregE,
    input  logic              regwriteE,
    input  logic              memtoregE,
    input  logic              divE,
    input  logic [REG_AW-1:0] writeregM,
    input  logic              regwriteM,
    input  logic              memtoregM,
    input  logic              excM,
    input  logic [REG_AW-1:0] writeregW,
    input  logic              regwriteW,
    output logic              forwardaD,
    output logic              forwardbD,
    output logic [1:0]        forwardaE,
    output logic [1:0]        forwardbE,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              stallM,
    output logic              flushD,
    output logic              flushE,
    output logic              flushM,
    output logic              flushW,
    output logic              div_busy,
    output logic              div_done,
    output logic [CNT_W-1:0]  stall_cnt
);
    import hazard_pkg::*;

    logic div_stall;
    logic lwstall, brstall;
    logic hit_e, hit_m;

    hazard_div_fsm #(.DIV_CYCLES(DIV_CYCLES)) u_div (
        .clk      (clk),
        .resetn   (resetn),
        .div_req  (divE),
        .exc      (excM),
        .div_busy (div_busy),
        .div_done (div_done),
        .div_stall(div_stall)
    );

    // Forwarding: register 0 is hard-wired, M is newer than W.
    always_comb begin
        forwardaE = FWD_RF;
        if (rsE != '0 && rsE == writeregM && regwriteM)      forwardaE = FWD_M;
        else if (rsE != '0 && rsE == writeregW && regwriteW) forwardaE = FWD_W;
        forwardbE = FWD_RF;
        if (rtE != '0 && rtE == writeregM && regwriteM)      forwardbE = FWD_M;
        else if (rtE != '0 && rtE == writeregW && regwriteW) forwardbE = FWD_W;
    end

    assign forwardaD = (rsD != '0) && (rsD == writeregM) && regwriteM;
    assign forwardbD = (rtD != '0) && (rtD == writeregM) && regwriteM;

    assign lwstall = memtoregE && (writeregE != '0) &&
                     ((writeregE == rsD) || (writeregE == rtD));
    assign hit_e   = regwriteE && (writeregE != '0) &&
                     ((writeregE == rsD) || (writeregE == rtD));
    assign hit_m   = memtoregM && (writeregM != '0) &&
                     ((writeregM == rsD) || (writeregM == rtD));
    assign brstall = (BRANCH_STALL != 0) && branchD && (hit_e || hit_m);

    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushM = 1'b0;
        flushW = 1'b0;
        if (excM) begin
            flushD = 1'b1;
            flushE = 1'b1;
            flushM = 1'b1;
        end else if (div_stall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            // M is held, so W gets a bubble to avoid a double write-back.
            flushW = 1'b1;
        end else if (lwstall || brstall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt <= '0;
        end else if (stallF && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
module tb_hazard_ctrl;
    localparam int AW  = 5;
    localparam int DC  = 4;
    localparam int CW  = 32;
    localparam int CW2 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          resetn;
    logic [AW-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic          branchD, regwriteE, memtoregE, divE;
    logic          regwriteM, memtoregM, excM, regwriteW;

    logic          forwardaD, forwardbD, stallF, stallD, stallE, stallM;
    logic          flushD, flushE, flushM, flushW, div_busy, div_done;
    logic [1:0]    forwardaE, forwardbE;
    logic [CW-1:0] stall_cnt;

    logic          forwardaD_b, forwardbD_b, stallF_b, stallD_b, stallE_b, stallM_b;
    logic          flushD_b, flushE_b, flushM_b, flushW_b, div_busy_b, div_done_b;
    logic [1:0]    forwardaE_b, forwardbE_b;
    logic [CW2-1:0] stall_cnt_b;

    hazard_ctrl #(.REG_AW(AW), .DIV_CYCLES(DC), .BRANCH_STALL(1), .CNT_W(CW)) dut_a (
        .clk(clk), .resetn(resetn), .rsD(rsD), .rtD(rtD), .branchD(branchD),
        .rsE(rsE), .rtE(rtE), .writeregE(writeregE), .regwriteE(regwriteE),
        .memtoregE(memtoregE), .divE(divE), .writeregM(writeregM),
        .regwriteM(regwriteM), .memtoregM(memtoregM), .excM(excM),
        .writeregW(writeregW), .regwriteW(regwriteW),
        .forwardaD(forwardaD), .forwardbD(forwardbD), .forwardaE(forwardaE),
        .forwardbE(forwardbE), .stallF(stallF), .stallD(stallD), .stallE(stallE),
        .stallM(stallM), .flushD(flushD), .flushE(flushE), .flushM(flushM),
        .flushW(flushW), .div_busy(div_busy), .div_done(div_done),
        .stall_cnt(stall_cnt)
    );

    hazard_ctrl #(.REG_AW(AW), .DIV_CYCLES(DC), .BRANCH_STALL(0), .CNT_W(CW2)) dut_b (
        .clk(clk), .resetn(resetn), .rsD(rsD), .rtD(rtD), .branchD(branchD),
        .rsE(rsE), .rtE(rtE), .writeregE(writeregE), .regwriteE(regwriteE),
        .memtoregE(memtoregE), .divE(divE), .writeregM(writeregM),
        .regwriteM(regwriteM), .memtoregM(memtoregM), .excM(excM),
        .writeregW(writeregW), .regwriteW(regwriteW),
        .forwardaD(forwardaD_b), .forwardbD(forwardbD_b), .forwardaE(forwardaE_b),
        .forwardbE(forwardbE_b), .stallF(stallF_b), .stallD(stallD_b), .stallE(stallE_b),
        .stallM(stallM_b), .flushD(flushD_b), .flushE(flushE_b), .flushM(flushM_b),
        .flushW(flushW_b), .div_busy(div_busy_b), .div_done(div_done_b),
        .stall_cnt(stall_cnt_b)
    );

    int     n_vec = 0;
    int     n_err = 0;
    // Reference model: rem = cycles the current divide still occupies E
    // after this one (0 = no divide in progress).
    int     rem   = 0;
    longint cnt_a = 0;
    int     cnt_b = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_fwd(input logic [AW-1:0] src);
        if (src != 0 && src == writeregM && regwriteM) return 2'b10;
        if (src != 0 && src == writeregW && regwriteW) return 2'b01;
        return 2'b00;
    endfunction

    // {stallF,stallD,stallE,stallM,flushD,flushE,flushM,flushW}
    function automatic logic [7:0] exp_ctl(input bit br_en);
        bit uses_e, uses_m, lw, br, dv;
        uses_e = regwriteE && writeregE != 0 && (writeregE == rsD || writeregE == rtD);
        uses_m = memtoregM && writeregM != 0 && (writeregM == rsD || writeregM == rtD);
        lw = memtoregE && writeregE != 0 && (writeregE == rsD || writeregE == rtD);
        br = br_en && branchD && (uses_e || uses_m);
        dv = (rem > 1) || (rem == 0 && divE);
        if (excM)    return 8'b0000_1110;
        if (dv)      return 8'b1111_0001;
        if (lw || br) return 8'b1100_0100;
        return 8'b0000_0000;
    endfunction

    task automatic check_all();
        chk("fwdaD", 32'(forwardaD), 32'(rsD != 0 && rsD == writeregM && regwriteM));
        chk("fwdbD", 32'(forwardbD), 32'(rtD != 0 && rtD == writeregM && regwriteM));
        chk("fwdaE", 32'(forwardaE), 32'(exp_fwd(rsE)));
        chk("fwdbE", 32'(forwardbE), 32'(exp_fwd(rtE)));
        chk("ctl_a", 32'({stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW}),
            32'(exp_ctl(1'b1)));
        chk("ctl_b", 32'({stallF_b, stallD_b, stallE_b, stallM_b,
                          flushD_b, flushE_b, flushM_b, flushW_b}), 32'(exp_ctl(1'b0)));
        chk("busy",  32'(div_busy), 32'(resetn && rem > 1));
        chk("done",  32'(div_done), 32'(resetn && rem == 1));
        chk("cnt_a", stall_cnt, 32'(cnt_a));
        chk("cnt_b", 32'(stall_cnt_b), 32'(cnt_b));
    endtask

    task automatic model_update();
        logic [7:0] ca, cb;
        if (!resetn) return;
        ca = exp_ctl(1'b1);
        cb = exp_ctl(1'b0);
        if (ca[7] && cnt_a < 64'hFFFF_FFFF) cnt_a++;
        if (cb[7] && cnt_b < 7) cnt_b++;
        if (excM)         rem = 0;
        else if (rem > 0) rem--;
        else if (divE)    rem = DC - 1;
    endtask

    // Called at a falling edge with inputs already applied.
    task automatic cyc();
        #1;
        check_all();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic clr_inputs();
        {rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW} = '0;
        {branchD, regwriteE, memtoregE, divE, regwriteM, memtoregM, excM, regwriteW} = '0;
    endtask

    longint c0;

    initial begin
        resetn = 1'b0;
        clr_inputs();
        @(negedge clk);
        #1;
        chk("rst_busy", 32'(div_busy), 32'd0);
        chk("rst_cnt",  stall_cnt, 32'd0);
        @(negedge clk);
        cyc();
        resetn = 1'b1;
        cyc();

        // Forwarding priority and register-0 rule
        rsE = 3; writeregM = 3; regwriteM = 1; writeregW = 3; regwriteW = 1;
        #1 chk("fwd_m_over_w", 32'(forwardaE), 32'h2);
        regwriteM = 0;
        #1 chk("fwd_w", 32'(forwardaE), 32'h1);
        rsE = 0;
        #1 chk("fwd_zero", 32'(forwardaE), 32'h0);
        cyc();
        clr_inputs();

        // Load-use: one stall cycle
        c0 = cnt_a;
        memtoregE = 1; writeregE = 8; rtD = 8;
        #1 chk("lw_stall", 32'({stallF, stallD, flushE}), 32'h7);
        cyc();
        clr_inputs();
        #1 chk("lw_release", 32'(stallF), 32'd0);
        cyc();
        chk("lw_cnt", stall_cnt, 32'(c0 + 1));

        // Branch stall enabled vs tied off
        branchD = 1; regwriteE = 1; writeregE = 5; rsD = 5;
        #1 chk("br_on",  32'(stallD),   32'd1);
        chk("br_off", 32'(stallD_b), 32'd0);
        cyc();
        clr_inputs();

        // Divide held in E by its own stall
        c0 = cnt_a;
        divE = 1;
        for (int i = 0; i < DC; i++) begin
            #1;
            chk("div_stallE", 32'(stallE),   32'(i < DC - 1));
            chk("div_done_t", 32'(div_done), 32'(i == DC - 1));
            cyc();
        end
        divE = 0;
        cyc();
        chk("div_cnt", stall_cnt, 32'(c0 + DC - 1));

        // Exception in the second RUN cycle
        divE = 1;
        cyc();
        cyc();
        excM = 1;
        #1 chk("exc_flush", 32'({flushD, flushE, flushM, flushW}), 32'hE);
        chk("exc_stalls", 32'({stallF, stallD, stallE, stallM}), 32'h0);
        cyc();
        excM = 0; divE = 0;
        #1 chk("exc_idle", 32'({div_busy, div_done}), 32'h0);
        cyc();

        // Asynchronous reset mid-RUN
        divE = 1;
        cyc();
        cyc();
        #2 resetn = 1'b0;
        #1 chk("arst_busy", 32'(div_busy), 32'd0);
        chk("arst_cnt", stall_cnt, 32'd0);
        rem = 0; cnt_a = 0; cnt_b = 0;
        divE = 0;
        @(negedge clk);
        cyc();
        resetn = 1'b1;
        divE = 1;
        for (int i = 0; i < DC; i++) begin
            #1 chk("restart_stallE", 32'(stallE), 32'(i < DC - 1));
            cyc();
        end
        divE = 0;

        // Drive the narrow counter into saturation
        memtoregE = 1; writeregE = 8; rsD = 8;
        for (int i = 0; i < 5; i++) cyc();
        chk("sat_b", 32'(stall_cnt_b), 32'd7);
        clr_inputs();
        cyc();

        // Randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            rsD       = AW'($urandom_range(0, 3));
            rtD       = AW'($urandom_range(0, 3));
            rsE       = AW'($urandom_range(0, 3));
            rtE       = AW'($urandom_range(0, 3));
            writeregE = AW'($urandom_range(0, 3));
            writeregM = AW'($urandom_range(0, 3));
            writeregW = AW'($urandom_range(0, 3));
            branchD   = 1'($urandom_range(0, 1));
            regwriteE = 1'($urandom_range(0, 1));
            memtoregE = 1'($urandom_range(0, 1));
            regwriteM = 1'($urandom_range(0, 1));
            memtoregM = 1'($urandom_range(0, 1));
            regwriteW = 1'($urandom_range(0, 1));
            divE      = ($urandom_range(0, 3) == 0);
            excM      = ($urandom_range(0, 15) == 0);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
